bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter sharing the single local bus (data memory plus memory-mapped GPIO registers) between the FemtoRV32 core (master 0) and a second requester such as a DMA or debug port (master 1). It sits between the masters and the address decoder. It serialises transfers with round-robin fairness, drives one strobe per transfer onto the shared bus, and returns a single-cycle completion pulse and read data to the winning master.

## Interface
- RD_LATENCY, 1: cycles from read strobe to valid s_rdata; legal range 1..15.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  transfer request; held high with fields stable until that master's ready.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte enables; nonzero = write, zero = read.
- m0_lock / m1_lock  in  1  keep grant for back-to-back transfers (see Configuration).
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  32  read data; valid only while own ready is high, else 0.
- s_addr  out  32  shared bus address.
- s_wdata  out  32  shared bus write data.
- s_wstrb  out  4  shared bus write strobe.
- s_rstrb  out  1  shared bus read strobe.
- s_rdata  in  32  shared bus read data (from decoder mux).
- gnt  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ACCESS: one strobe cycle.
  - WAIT: read only, RD_LATENCY-1 cycles.
  - RESP: ready pulse.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both req: grant the master not equal to last_grant.
  - On grant: latch index into gnt, update last_grant, go to ACCESS.
- ACCESS:
  - Granted master's addr/wdata are driven on s_addr/s_wdata.
  - Write: s_wstrb = master wstrb for exactly this cycle; go to RESP.
  - Read: s_rstrb = 1 for exactly this cycle; go to WAIT, or directly to RESP if RD_LATENCY = 1.
- WAIT: 4-bit down-counter loaded with RD_LATENCY-1 on entry to WAIT. Go to RESP when the counter reaches 1.
- RESP:
  - Granted master's ready = 1.
  - Read: that master's rdata = s_rdata, passed through combinationally.
  - Next state IDLE. With lock, next state is defined under Configuration.
- s_addr, s_wdata, s_wstrb and s_rstrb are all 0 outside ACCESS. s_addr and s_wdata are also 0 in WAIT and RESP.
- Non-granted master's ready and rdata are always 0.
- A req still high in the cycle after ready is treated as a new request. Masters drop req or present the next transfer in that cycle.
- req deasserted before ready: illegal. The arbiter completes the latched transfer regardless.

## Timing
- Reset values:
  - State IDLE, gnt = 00, busy = 0.
  - All ready = 0, rdata = 0.
  - All s_* outputs = 0.
  - last_grant = master 1, so master 0 wins the first simultaneous request.
- req sampled in cycle N (IDLE):
  - Strobe in N+1.
  - Write ready in N+2.
  - Read ready in N+1+RD_LATENCY.
- Throughput: one write every 3 cycles; one read every 2+RD_LATENCY cycles.
- rst asserted mid-transfer: the next edge returns all state to reset values. No ready is issued and the in-flight transfer is dropped, so the master must reissue. A write already strobed in ACCESS is not undone.
- Simultaneous new req from the loser while the winner is in RESP: served at the next IDLE, ahead of the winner's re-request (round robin).

## Configuration
- Macro: BUS_ARB_LOCK_EN.
- Defined:
  - If the granted master has lock = 1 and req = 1 in RESP, the FSM goes RESP -> ACCESS directly, skipping IDLE.
  - gnt and last_grant are unchanged, and the next transfer's fields are taken in ACCESS.
  - Locked throughput is one write every 2 cycles.
  - Starvation of the other master is software's responsibility.
- Undefined: m0_lock/m1_lock are ignored, and RESP always goes to IDLE.

## Test plan
- Reset then single m0 write (addr 0x0000_0010, wdata 0xDEAD_BEEF, wstrb 4'hF) at cycle 0 -> s_wstrb = 4'hF with s_addr 0x10 at cycle 1; m0_ready at cycle 2; m1_ready stays 0.
- m1 read with RD_LATENCY = 3, s_rdata model returning 0x1234_5678 three cycles after strobe -> s_rstrb at cycle 1; m1_ready and m1_rdata = 0x1234_5678 at cycle 4; m0_rdata = 0.
- Both masters issue continuous writes -> grants alternate m0, m1, m0, m1, with each ready 3 cycles apart and no master granted twice in a row.
- rst pulsed during WAIT of a read (RD_LATENCY = 4) -> no ready ever pulses for that read; gnt = 00 and busy = 0 the cycle after reset; a fresh m0 read then completes normally.
- With BUS_ARB_LOCK_EN, m0 holds lock and req for 3 writes while m1 requests -> m0_ready at cycles 2, 4, 6; m1 is granted only after m0 drops lock, with m1 strobe 2 cycles after m0's last ready.
- Without BUS_ARB_LOCK_EN, same stimulus -> grants alternate m0, m1, m0 regardless of lock.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: the two requester ports and the shared-bus port of bus_arbiter.
// slave is the arbiter's view of the bundle; master is the view of the masters and the bus.
`default_nettype none

interface bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_lock;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_lock;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_rstrb;
  logic [31:0] s_rdata;

  logic [1:0]  gnt;
  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_wstrb, m0_lock,
    output m0_ready, m0_rdata,
    input  m1_req, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output m1_ready, m1_rdata,
    output s_addr, s_wdata, s_wstrb, s_rstrb,
    input  s_rdata,
    output gnt, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_wstrb, m0_lock,
    input  m0_ready, m0_rdata,
    output m1_req, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  m1_ready, m1_rdata,
    input  s_addr, s_wdata, s_wstrb, s_rstrb,
    output s_rdata,
    input  gnt, busy
  );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Round-robin two-master arbiter for the shared local bus; one
//            strobe per transfer, one-cycle ready pulse back to the owner.
//            Optional macro BUS_ARB_LOCK_EN enables locked back-to-back bursts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [3:0] c_WAIT_INIT = 4'(RD_LATENCY - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_gnt, w_gnt_nxt;
  logic        r_last, w_last_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_is_rd, w_is_rd_nxt;

  logic        w_sel;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wstrb;
  logic        w_lock_hold;

  logic [31:0] w_s_addr;
  logic [31:0] w_s_wdata;
  logic [3:0]  w_s_wstrb;
  logic        w_s_rstrb;
  logic [1:0]  w_ready;
  logic [31:0] w_rdata;

  // Owner fields are taken straight from the master, which holds them until ready
  assign w_sel       = r_gnt[1];
  assign w_sel_addr  = w_sel ? bus.m1_addr  : bus.m0_addr;
  assign w_sel_wdata = w_sel ? bus.m1_wdata : bus.m0_wdata;
  assign w_sel_wstrb = w_sel ? bus.m1_wstrb : bus.m0_wstrb;

`ifdef BUS_ARB_LOCK_EN
  logic w_sel_req;
  logic w_sel_lock;
  assign w_sel_req   = w_sel ? bus.m1_req  : bus.m0_req;
  assign w_sel_lock  = w_sel ? bus.m1_lock : bus.m0_lock;
  assign w_lock_hold = w_sel_req & w_sel_lock;
`else
  logic w_unused_lock;
  assign w_unused_lock = ^{bus.m0_lock, bus.m1_lock};
  assign w_lock_hold   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_cnt   <= 4'd0;
      r_is_rd <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_rd <= w_is_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_is_rd_nxt = r_is_rd;
    w_s_addr    = 32'd0;
    w_s_wdata   = 32'd0;
    w_s_wstrb   = 4'd0;
    w_s_rstrb   = 1'b0;
    w_ready     = 2'b00;
    w_rdata     = 32'd0;

    case (r_state)
      ST_IDLE: begin
        // On contention the master that did not win last time goes first
        if (bus.m0_req && (!bus.m1_req || r_last)) begin
          w_gnt_nxt   = 2'b01;
          w_last_nxt  = 1'b0;
          w_state_nxt = ST_ACCESS;
        end else if (bus.m1_req) begin
          w_gnt_nxt   = 2'b10;
          w_last_nxt  = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        w_s_addr  = w_sel_addr;
        w_s_wdata = w_sel_wdata;
        if (w_sel_wstrb != 4'd0) begin
          w_s_wstrb   = w_sel_wstrb;
          w_is_rd_nxt = 1'b0;
          w_state_nxt = ST_RESP;
        end else begin
          w_s_rstrb   = 1'b1;
          w_is_rd_nxt = 1'b1;
          if (RD_LATENCY == 1) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_cnt_nxt   = c_WAIT_INIT;
            w_state_nxt = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      ST_RESP: begin
        w_ready = r_gnt;
        w_rdata = r_is_rd ? bus.s_rdata : 32'd0;
        if (w_lock_hold) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_gnt_nxt   = 2'b00;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.s_addr   = w_s_addr;
  assign bus.s_wdata  = w_s_wdata;
  assign bus.s_wstrb  = w_s_wstrb;
  assign bus.s_rstrb  = w_s_rstrb;
  assign bus.m0_ready = w_ready[0];
  assign bus.m1_ready = w_ready[1];
  assign bus.m0_rdata = w_ready[0] ? w_rdata : 32'd0;
  assign bus.m1_rdata = w_ready[1] ? w_rdata : 32'd0;
  assign bus.gnt      = r_gnt;
  assign bus.busy     = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter with two instances (RD_LATENCY 3 and 4).
// Expected values are hand-derived cycle tables; lock expectations follow BUS_ARB_LOCK_EN.
`default_nettype none

module tb_bus_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_arbiter_if ifa();
  bus_arbiter_if ifb();

  bus_arbiter #(.RD_LATENCY(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bus_arbiter #(.RD_LATENCY(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-data models: data appears RD_LATENCY cycles after the strobe cycle
  logic [2:0] r_pipe_a;
  logic [3:0] r_pipe_b;
  always @(posedge clk) begin
    if (rst) begin
      r_pipe_a <= 3'd0;
      r_pipe_b <= 4'd0;
    end else begin
      r_pipe_a <= {r_pipe_a[1:0], ifa.s_rstrb};
      r_pipe_b <= {r_pipe_b[2:0], ifb.s_rstrb};
    end
  end
  assign ifa.s_rdata = r_pipe_a[2] ? 32'h1234_5678 : 32'h0;
  assign ifb.s_rdata = r_pipe_b[3] ? 32'hCAFE_F00D : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.m0_req = 0; ifa.m0_addr = 0; ifa.m0_wdata = 0; ifa.m0_wstrb = 0; ifa.m0_lock = 0;
    ifa.m1_req = 0; ifa.m1_addr = 0; ifa.m1_wdata = 0; ifa.m1_wstrb = 0; ifa.m1_lock = 0;
    ifb.m0_req = 0; ifb.m0_addr = 0; ifb.m0_wdata = 0; ifb.m0_wstrb = 0; ifb.m0_lock = 0;
    ifb.m1_req = 0; ifb.m1_addr = 0; ifb.m1_wdata = 0; ifb.m1_wstrb = 0; ifb.m1_lock = 0;
  endtask

  logic [1:0]  t3_gnt [12];
  logic [11:0] t3_r0, t3_r1;
  logic [1:0]  t4_gnt [13];
  logic [12:0] t4_r0, t4_r1;
  int          rem0, rem1;
  logic        p0, p1;

  initial begin
    checks = 0;
    errors = 0;

    t3_gnt = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
               2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    t3_r0  = 12'h104;
    t3_r1  = 12'h820;
`ifdef BUS_ARB_LOCK_EN
    t4_gnt = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
               2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    t4_r0  = 13'h0054;
    t4_r1  = 13'h0200;
`else
    t4_gnt = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
               2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    t4_r0  = 13'h0904;
    t4_r1  = 13'h0020;
`endif

    // Reset state
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    @(negedge clk);
    chk("rst_gnt",     32'(ifa.gnt), 32'd0);
    chk("rst_busy",    32'(ifa.busy), 32'd0);
    chk("rst_m0_rdy",  32'(ifa.m0_ready), 32'd0);
    chk("rst_m1_rdy",  32'(ifa.m1_ready), 32'd0);
    chk("rst_s_wstrb", 32'(ifa.s_wstrb), 32'd0);
    chk("rst_s_rstrb", 32'(ifa.s_rstrb), 32'd0);
    chk("rst_s_addr",  ifa.s_addr, 32'd0);
    chk("rst_m0_rdata", ifa.m0_rdata, 32'd0);
    chk("rst_b_gnt",   32'(ifb.gnt), 32'd0);
    chk("rst_b_busy",  32'(ifb.busy), 32'd0);

    // Single m0 write
    tick();
    rst = 1'b0;
    ifa.m0_req = 1; ifa.m0_addr = 32'h10; ifa.m0_wdata = 32'hDEAD_BEEF; ifa.m0_wstrb = 4'hF;
    @(negedge clk);
    chk("wr_c0_busy", 32'(ifa.busy), 32'd0);
    chk("wr_c0_wstrb", 32'(ifa.s_wstrb), 32'd0);
    tick();
    @(negedge clk);
    chk("wr_c1_wstrb", 32'(ifa.s_wstrb), 32'hF);
    chk("wr_c1_addr",  ifa.s_addr, 32'h10);
    chk("wr_c1_wdata", ifa.s_wdata, 32'hDEAD_BEEF);
    chk("wr_c1_gnt",   32'(ifa.gnt), 32'b01);
    chk("wr_c1_rdy",   32'(ifa.m0_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("wr_c2_m0_rdy", 32'(ifa.m0_ready), 32'd1);
    chk("wr_c2_m1_rdy", 32'(ifa.m1_ready), 32'd0);
    chk("wr_c2_wstrb",  32'(ifa.s_wstrb), 32'd0);
    chk("wr_c2_addr",   ifa.s_addr, 32'd0);
    tick();
    ifa.m0_req = 0;
    @(negedge clk);
    chk("wr_c3_busy", 32'(ifa.busy), 32'd0);
    chk("wr_c3_gnt",  32'(ifa.gnt), 32'd0);

    // m1 read, RD_LATENCY = 3
    tick();
    ifa.m1_req = 1; ifa.m1_addr = 32'h20; ifa.m1_wstrb = 4'h0;
    @(negedge clk);
    chk("rd_c0_rstrb", 32'(ifa.s_rstrb), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_c1_rstrb", 32'(ifa.s_rstrb), 32'd1);
    chk("rd_c1_addr",  ifa.s_addr, 32'h20);
    chk("rd_c1_wstrb", 32'(ifa.s_wstrb), 32'd0);
    chk("rd_c1_gnt",   32'(ifa.gnt), 32'b10);
    tick();
    @(negedge clk);
    chk("rd_c2_rstrb", 32'(ifa.s_rstrb), 32'd0);
    chk("rd_c2_addr",  ifa.s_addr, 32'd0);
    chk("rd_c2_busy",  32'(ifa.busy), 32'd1);
    chk("rd_c2_rdy",   32'(ifa.m1_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_c3_rdy", 32'(ifa.m1_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("rd_c4_rdy",      32'(ifa.m1_ready), 32'd1);
    chk("rd_c4_rdata",    ifa.m1_rdata, 32'h1234_5678);
    chk("rd_c4_m0_rdata", ifa.m0_rdata, 32'd0);
    chk("rd_c4_m0_rdy",   32'(ifa.m0_ready), 32'd0);
    tick();
    ifa.m1_req = 0;
    @(negedge clk);
    chk("rd_c5_busy",  32'(ifa.busy), 32'd0);
    chk("rd_c5_rdata", ifa.m1_rdata, 32'd0);

    // Both masters issue continuous writes: grants alternate
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        ifa.m0_req = 1; ifa.m0_addr = 32'h100; ifa.m0_wdata = 32'hA0A0_A0A0; ifa.m0_wstrb = 4'hF;
        ifa.m1_req = 1; ifa.m1_addr = 32'h200; ifa.m1_wdata = 32'hB0B0_B0B0; ifa.m1_wstrb = 4'h3;
      end
      @(negedge clk);
      chk($sformatf("rr_gnt_c%0d", c),  32'(ifa.gnt), 32'(t3_gnt[c]));
      chk($sformatf("rr_rdy0_c%0d", c), 32'(ifa.m0_ready), 32'(t3_r0[c]));
      chk($sformatf("rr_rdy1_c%0d", c), 32'(ifa.m1_ready), 32'(t3_r1[c]));
    end
    tick();
    ifa.m0_req = 0;
    ifa.m1_req = 0;
    @(negedge clk);
    chk("rr_end_busy", 32'(ifa.busy), 32'd0);

    // m0 locked burst of 3 writes against a pending m1 write
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 13; c++) begin
      tick();
      if (c == 0) begin
        ifa.m0_req = 1; ifa.m0_lock = 1; ifa.m0_addr = 32'h300; ifa.m0_wdata = 32'h1111_1111; ifa.m0_wstrb = 4'hF;
        ifa.m1_req = 1; ifa.m1_lock = 0; ifa.m1_addr = 32'h400; ifa.m1_wdata = 32'h2222_2222; ifa.m1_wstrb = 4'h3;
        rem0 = 3;
        rem1 = 1;
      end else begin
        if (p0) begin
          rem0--;
          if (rem0 == 1) ifa.m0_lock = 0;
          if (rem0 == 0) ifa.m0_req = 0;
        end
        if (p1) begin
          rem1--;
          if (rem1 == 0) ifa.m1_req = 0;
        end
      end
      @(negedge clk);
      chk($sformatf("lk_gnt_c%0d", c),  32'(ifa.gnt), 32'(t4_gnt[c]));
      chk($sformatf("lk_rdy0_c%0d", c), 32'(ifa.m0_ready), 32'(t4_r0[c]));
      chk($sformatf("lk_rdy1_c%0d", c), 32'(ifa.m1_ready), 32'(t4_r1[c]));
      p0 = ifa.m0_ready;
      p1 = ifa.m1_ready;
    end
    ifa.m0_req = 0;
    ifa.m1_req = 0;

    // Reset during WAIT of a read on the RD_LATENCY = 4 instance
    tick();
    ifb.m0_req = 1; ifb.m0_addr = 32'h40; ifb.m0_wstrb = 4'h0;
    @(negedge clk);
    chk("rr4_c0_busy", 32'(ifb.busy), 32'd0);
    tick();
    @(negedge clk);
    chk("rr4_c1_rstrb", 32'(ifb.s_rstrb), 32'd1);
    chk("rr4_c1_addr",  ifb.s_addr, 32'h40);
    tick();
    @(negedge clk);
    chk("rr4_c2_busy",  32'(ifb.busy), 32'd1);
    chk("rr4_c2_rstrb", 32'(ifb.s_rstrb), 32'd0);
    tick();
    rst = 1'b1;
    ifb.m0_req = 0;
    @(negedge clk);
    chk("rr4_c3_rdy", 32'(ifb.m0_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rr4_c4_gnt",  32'(ifb.gnt), 32'd0);
    chk("rr4_c4_busy", 32'(ifb.busy), 32'd0);
    chk("rr4_c4_rdy",  32'(ifb.m0_ready), 32'd0);
    for (int c = 5; c < 9; c++) begin
      tick();
      @(negedge clk);
      chk($sformatf("rr4_c%0d_rdy", c), 32'(ifb.m0_ready), 32'd0);
    end

    // Fresh m0 read completes normally after reset
    tick();
    ifb.m0_req = 1; ifb.m0_addr = 32'h44; ifb.m0_wstrb = 4'h0;
    tick();
    @(negedge clk);
    chk("fr_c1_rstrb", 32'(ifb.s_rstrb), 32'd1);
    chk("fr_c1_addr",  ifb.s_addr, 32'h44);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("fr_c4_rdy", 32'(ifb.m0_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("fr_c5_rdy",      32'(ifb.m0_ready), 32'd1);
    chk("fr_c5_rdata",    ifb.m0_rdata, 32'hCAFE_F00D);
    chk("fr_c5_m1_rdata", ifb.m1_rdata, 32'd0);
    tick();
    ifb.m0_req = 0;
    @(negedge clk);
    chk("fr_c6_busy", 32'(ifb.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
